ped_signal_ctrl: RTL and testbench
==================================

# ped_signal_ctrl

Pedestrian signal controller sitting directly downstream of the `traffic_light` vehicle controller. It consumes the `red`/`yellow`/`green` lamp outputs and drives the pedestrian WALK / DON'T WALK heads, including the flashing clearance phase and its countdown. It also debounces and latches the pedestrian push-button request. Walk is granted only while the vehicle head is red.

## Interface
- `WALK_CYCLES`, 8: cycles WALK is lit; legal range 1..255.
- `CLEAR_CYCLES`, 6: cycles of flashing clearance; legal range 1..15.
- `FLASH_DIV`, 2: clearance flash half-period in cycles; legal range 1..15.
- `DEBOUNCE`, 3: consecutive high samples of `btn` needed to register a press; legal range 1..15.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn` in 1: pedestrian push-button, already synchronous to `clk`.
- `red`, `yellow`, `green` in 1 each: lamp outputs from `traffic_light`.
- `walk` out 1: WALK head.
- `dont_walk` out 1: DON'T WALK head.
- `countdown` out 4: clearance seconds-remaining display.
- `req_pending` out 1: latched pedestrian request.

## Operation
- Red-edge detect: `red_q` register holds the previous `red`. Edge = `red & ~red_q & ~yellow & ~green`. `red_q` resets to 1, so a red already active at reset release never grants.
- `red_ok` = `red & ~yellow & ~green`. Any other lamp combination, including all-off, counts as not red.
- FSM states are IDLE, WALK and CLEAR.
  - IDLE: `walk`=0, `dont_walk`=1, `countdown`=0. On edge with `req_pending`=1, go to WALK.
  - WALK: `walk`=1, `dont_walk`=0. Stay WALK_CYCLES cycles, then go to CLEAR.
  - CLEAR: `walk`=0, `dont_walk`=`flash`. `flash` starts at 1 on entry and toggles every FLASH_DIV cycles. `countdown` = cycles remaining including the current one (CLEAR_CYCLES down to 1). After CLEAR_CYCLES cycles, go to IDLE.
- Safety abort: `red_ok`=0 in WALK or CLEAR forces IDLE on the next edge. This takes priority over every other transition. `req_pending` is not restored.
- Debounce counter:
  - Increments while `btn`=1, saturating at DEBOUNCE. Clears when `btn`=0.
  - Held at 0 while in WALK.
  - When the count reaches DEBOUNCE, `req_pending` sets on the next cycle.
  - A continuous hold produces exactly one set per press.
- `req_pending` clears on entry to WALK. A grant decision uses the registered `req_pending`. A request completing in the same cycle as the edge therefore misses that red and waits for the next one.
- Reset values:
  - State IDLE.
  - `walk`=0, `dont_walk`=1, `countdown`=0, `req_pending`=0.
  - `flash` and all counters 0.

## Timing
- Edge sampled at cycle N → `walk`=1 from cycle N+1 through N+WALK_CYCLES.
- CLEAR occupies cycles N+WALK_CYCLES+1 through N+WALK_CYCLES+CLEAR_CYCLES.
- `dont_walk`=1 steadily from N+WALK_CYCLES+CLEAR_CYCLES+1.
- All outputs are registered; no combinational path from inputs to outputs.
- `walk` and `dont_walk` are never 1 in the same cycle. The only cycles with both at 0 are CLEAR flash-off phases.
- Abort: `red_ok` drops at cycle M → `walk`=0 and `dont_walk`=1 at M+1.
- `rst` mid-phase: outputs reach reset values on the following edge regardless of state.

## Configuration
- `PED_REQ_EN` defined: behaviour as above; WALK requires a latched request.
- `PED_REQ_EN` undefined:
  - Every qualified red edge grants WALK.
  - `btn` is ignored.
  - `req_pending` is tied to 0.
  - No debounce logic is built.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with `red`=1, then release → `walk`=0, `dont_walk`=1, `countdown`=0, `req_pending`=0, and no WALK for this red.
- **Request and grant (`PED_REQ_EN`, defaults):** `btn`=1 for 3 cycles → `req_pending`=1 one cycle later. Next red edge at N → `walk`=1 for cycles N+1..N+8, then `countdown` reads 6,5,4,3,2,1 with `dont_walk` 1,1,0,0,1,1, then IDLE.
- **Debounce reject:** `btn` pulses of 1 or 2 cycles separated by lows → `req_pending` stays 0 and a red edge yields no WALK.
- **Abort:** `red` drops to 0 (and `green` rises) at WALK cycle 4 → next cycle `walk`=0, `dont_walk`=1, `countdown`=0; the state stays IDLE through the following green.
- **Illegal lamps:** `red`=1 and `yellow`=1 together at the would-be edge → no grant; `req_pending` remains 1 and is serviced at the next clean red edge.
- **`PED_REQ_EN` undefined:** `btn` held at 0, two consecutive red phases → WALK is granted on both with identical timing.

Source files
------------

// File: rtl/ped_signal_ctrl.sv
// ped_signal_ctrl
// Pedestrian WALK / DON'T WALK controller that follows the vehicle head of
// traffic_light. WALK is granted on a clean red edge, then a flashing
// clearance phase with a countdown follows. The grant is dropped
// immediately if the vehicle head stops showing a clean red.
//
// Configuration macro: PED_REQ_EN
//   defined   - a debounced, latched push-button request is needed for WALK.
//   undefined - every clean red edge grants WALK, btn is ignored and
//               req_pending is tied low.

module ped_signal_ctrl #(
    parameter int WALK_CYCLES  = 8,   // 1..255
    parameter int CLEAR_CYCLES = 6,   // 1..15
    parameter int FLASH_DIV    = 2,   // 1..15
    parameter int DEBOUNCE     = 3    // 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    output logic       walk,
    output logic       dont_walk,
    output logic [3:0] countdown,
    output logic       req_pending
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t     state;
    logic       red_q;
    logic       red_ok;
    logic       red_edge;
    logic       req_ok;
    logic       grant;
    logic [7:0] walk_cnt;
    logic [3:0] flash_cnt;
    logic       flash;

    // Only red with the other two lamps dark counts as red; all-off is not red.
    assign red_ok   = red & ~yellow & ~green;
    assign red_edge = red_ok & ~red_q;
    assign grant    = (state == IDLE) && red_edge && req_ok;

    // Previous red lamp for edge detection; resets high so a red that is
    // already lit when reset releases never grants WALK.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked block and
        // only takes effect on a rising edge.
        if (rst) begin
            red_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples values from before the edge.
            red_q <= red;
        end
    end

    // Main phase FSM with registered lamp and countdown outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            countdown <= 4'd0;
            walk_cnt  <= 8'd0;
            flash_cnt <= 4'd0;
            flash     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state     <= WALK;
                        walk      <= 1'b1;
                        dont_walk <= 1'b0;
                        walk_cnt  <= 8'(WALK_CYCLES - 1);
                    end
                end

                WALK: begin
                    if (!red_ok) begin
                        // Vehicle head left clean red: abort straight to IDLE.
                        state     <= IDLE;
                        walk      <= 1'b0;
                        dont_walk <= 1'b1;
                        countdown <= 4'd0;
                    end else if (walk_cnt == 8'd0) begin
                        state     <= CLEAR;
                        walk      <= 1'b0;
                        dont_walk <= 1'b1;
                        countdown <= 4'(CLEAR_CYCLES);
                        flash     <= 1'b1;
                        flash_cnt <= 4'(FLASH_DIV - 1);
                    end else begin
                        walk_cnt <= walk_cnt - 8'd1;
                    end
                end

                CLEAR: begin
                    if (!red_ok || countdown == 4'd1) begin
                        // Either an abort or the last clearance cycle.
                        state     <= IDLE;
                        walk      <= 1'b0;
                        dont_walk <= 1'b1;
                        countdown <= 4'd0;
                        flash     <= 1'b0;
                        flash_cnt <= 4'd0;
                    end else begin
                        countdown <= countdown - 4'd1;
                        if (flash_cnt == 4'd0) begin
                            flash     <= ~flash;
                            dont_walk <= ~flash;
                            flash_cnt <= 4'(FLASH_DIV - 1);
                        end else begin
                            flash_cnt <= flash_cnt - 4'd1;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    walk      <= 1'b0;
                    dont_walk <= 1'b1;
                    countdown <= 4'd0;
                end
            endcase
        end
    end

`ifdef PED_REQ_EN
    logic [3:0] deb_cnt;
    logic       press_done;

    // A press completes on the sample that brings the count up to DEBOUNCE;
    // the count then saturates so a long hold sets the request only once.
    assign press_done = btn && (state != WALK) && (deb_cnt == 4'(DEBOUNCE - 1));
    assign req_ok     = req_pending;

    // Button debounce and request latch; the grant consumes the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt     <= 4'd0;
            req_pending <= 1'b0;
        end else begin
            if (state == WALK || !btn) begin
                deb_cnt <= 4'd0;
            end else if (deb_cnt != 4'(DEBOUNCE)) begin
                deb_cnt <= deb_cnt + 4'd1;
            end

            if (grant) begin
                req_pending <= 1'b0;
            end else if (press_done) begin
                req_pending <= 1'b1;
            end
        end
    end
`else
    logic unused_btn;

    // Without requests every clean red edge grants and the button is unused.
    assign req_ok      = 1'b1;
    assign req_pending = 1'b0;
    assign unused_btn  = btn;
`endif

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Testbench for ped_signal_ctrl. Stimulus tasks drive lamp / button
// sequences and push the expected outputs into a queue; a monitor process
// pops one entry per clock and compares it with the DUT outputs.
// The reference model describes the outputs as a function of the number of
// cycles elapsed since the last grant.

module tb_ped_signal_ctrl;

    localparam int W  = 8;
    localparam int C  = 6;
    localparam int FD = 2;
    localparam int D  = 3;

`ifdef PED_REQ_EN
    localparam bit REQ_MODE = 1'b1;
`else
    localparam bit REQ_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       red = 1'b1;
    logic       yellow = 1'b0;
    logic       green = 1'b0;
    logic       walk;
    logic       dont_walk;
    logic [3:0] countdown;
    logic       req_pending;

    always #5 clk = ~clk;

    ped_signal_ctrl #(
        .WALK_CYCLES (W),
        .CLEAR_CYCLES(C),
        .FLASH_DIV   (FD),
        .DEBOUNCE    (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .walk       (walk),
        .dont_walk  (dont_walk),
        .countdown  (countdown),
        .req_pending(req_pending)
    );

    typedef struct packed {
        logic       walk;
        logic       dont_walk;
        logic [3:0] cd;
        logic       req;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: edge index, edge index of last grant (-1 none),
    // button run length, latched request, previous red lamp.
    int m_k   = 0;
    int m_g   = -1;
    int m_run = 0;
    bit m_req = 1'b0;
    bit m_prev_red = 1'b1;
    int btn_left = 0;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got walk/dw/cd/req=%b, expected %b", name, $time, act, req);
        end
    endtask

    // Advance the model by one clock edge with the inputs sampled at that edge.
    function automatic exp_t model_step(input bit r_st, b, rd, yl, gr);
        exp_t e;
        int   jp;
        int   j;
        bit   ok, edge_s, active_prev, walk_prev, granted, set_ev;
        m_k++;
        if (r_st) begin
            m_g = -1; m_req = 1'b0; m_run = 0; m_prev_red = 1'b1;
        end else begin
            ok          = rd && !yl && !gr;
            edge_s      = ok && !m_prev_red;
            m_prev_red  = rd;
            jp          = m_k - 1 - m_g;
            active_prev = (m_g >= 0) && (jp >= 0) && (jp < W + C);
            walk_prev   = active_prev && (jp < W);
            granted     = 1'b0;
            if (active_prev && !ok) begin
                m_g = -1;
            end else if (!active_prev && edge_s && (!REQ_MODE || m_req)) begin
                m_g = m_k;
                granted = 1'b1;
            end
            set_ev = b && !walk_prev && (m_run == D - 1);
            if (walk_prev || !b) m_run = 0;
            else if (m_run < D)  m_run = m_run + 1;
            if (granted)     m_req = 1'b0;
            else if (set_ev) m_req = 1'b1;
        end
        e.walk = 1'b0; e.dont_walk = 1'b1; e.cd = 4'd0;
        j = m_k - m_g;
        if (m_g >= 0 && j < W + C) begin
            if (j < W) begin
                e.walk = 1'b1; e.dont_walk = 1'b0;
            end else begin
                e.dont_walk = (((j - W) / FD) % 2) == 0;
                e.cd        = 4'(W + C - j);
            end
        end
        e.req = REQ_MODE ? m_req : 1'b0;
        return e;
    endfunction

    // One clock of stimulus: drive at the falling edge, queue the expectation
    // for the outputs seen after the next rising edge.
    task automatic step(input bit r_st, b, rd, yl, gr);
        @(negedge clk);
        rst = r_st; btn = b; red = rd; yellow = yl; green = gr;
        exp_q.push_back(model_step(r_st, b, rd, yl, gr));
    endtask

    // n cycles of a fixed lamp pattern with a button held low.
    task automatic hold(input int n, input bit rd, yl, gr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rd, yl, gr);
    endtask

    // n cycles of a fixed lamp pattern with random button presses of 1..5 cycles.
    task automatic drive(input int n, input bit rd, yl, gr);
        bit b;
        for (int i = 0; i < n; i++) begin
            if (btn_left == 0 && $urandom_range(0, 9) == 0) btn_left = $urandom_range(1, 5);
            b = (btn_left > 0);
            if (b) btn_left--;
            step(1'b0, b, rd, yl, gr);
        end
    endtask

    // Monitor: compare one queued expectation per clock, just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", {walk, dont_walk, countdown, req_pending}, e);
            end
        end
    end

    initial begin
        // Reset held two cycles with red lit, then red stays: no grant.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        hold(12, 1'b1, 1'b0, 1'b0);

        // Request (3-cycle press during green) and grant on next red edge.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        hold(3, 1'b0, 1'b0, 1'b1);
        hold(2, 1'b0, 1'b1, 1'b0);
        hold(20, 1'b1, 1'b0, 1'b0);

        // Debounce reject: pulses of 1 and 2 cycles separated by lows.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        hold(2, 1'b0, 1'b1, 1'b0);
        hold(18, 1'b1, 1'b0, 1'b0);

        // Abort: red drops and green rises at WALK cycle 4.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        hold(2, 1'b0, 1'b0, 1'b1);
        hold(2, 1'b0, 1'b1, 1'b0);
        hold(5, 1'b1, 1'b0, 1'b0);
        hold(8, 1'b0, 1'b0, 1'b1);
        hold(2, 1'b0, 1'b1, 1'b0);
        hold(4, 1'b1, 1'b0, 1'b0);

        // Illegal lamps at the would-be edge, request serviced next clean red.
        hold(2, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        hold(2, 1'b0, 1'b1, 1'b0);
        hold(2, 1'b1, 1'b1, 1'b0);
        hold(10, 1'b1, 1'b0, 1'b0);
        hold(3, 1'b0, 1'b0, 1'b1);
        hold(2, 1'b0, 1'b1, 1'b0);
        hold(18, 1'b1, 1'b0, 1'b0);

        // Two consecutive red phases with the button idle.
        for (int p = 0; p < 2; p++) begin
            hold(4, 1'b0, 1'b0, 1'b1);
            hold(2, 1'b0, 1'b1, 1'b0);
            hold(17, 1'b1, 1'b0, 1'b0);
        end

        // Randomised light cycles with button presses, glitches and resets.
        for (int p = 0; p < 40; p++) begin
            int kind;
            int split;
            if ($urandom_range(0, 19) == 0) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            drive($urandom_range(3, 8), 1'b0, 1'b0, 1'b1);
            drive($urandom_range(1, 3), 1'b0, 1'b1, 1'b0);
            kind = $urandom_range(0, 7);
            if (kind == 0) begin
                drive(2, 1'b1, 1'b1, 1'b0);
                drive($urandom_range(10, 20), 1'b1, 1'b0, 1'b0);
            end else if (kind == 1) begin
                split = $urandom_range(2, 12);
                drive(split, 1'b1, 1'b0, 1'b0);
                drive(1, 1'b0, 1'b0, 1'b0);
                drive($urandom_range(16, 24), 1'b1, 1'b0, 1'b0);
            end else if (kind == 2) begin
                drive($urandom_range(12, 24), 1'b1, 1'b0, 1'b0);
                step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
                drive(4, 1'b1, 1'b0, 1'b0);
            end else begin
                drive($urandom_range(16, 28), 1'b1, 1'b0, 1'b0);
            end
        end

        hold(3, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 7'(exp_q.size()), 7'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
